// File: rtl/mario_jump_ctrl.sv
// Vertical motion controller for Mario: jump/rise/fall physics stepped once per video frame.
// Position, speed and state are registered and update one clk after frame_tick.
module mario_jump_ctrl #(
  parameter int Y_INIT  = 407,
  parameter int Y_FLOOR = 407,
  parameter int Y_CEIL  = 0,
  parameter int JUMP_V0 = 12,
  parameter int GRAVITY = 1,
  parameter int V_MAX   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_jump,
  input  logic       ground,
  input  logic       head_hit,
  output logic [9:0] mario_y,
  output logic [3:0] vy,
  output logic [1:0] state,
  output logic       airborne
);

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2
  } state_t;

  localparam logic [9:0]  Y_INIT_W   = 10'(Y_INIT);
  localparam logic [9:0]  Y_FLOOR_Y  = 10'(Y_FLOOR);
  localparam logic [10:0] Y_FLOOR_W  = 11'(Y_FLOOR);
  localparam logic [9:0]  Y_CEIL_Y   = 10'(Y_CEIL);
  localparam logic [10:0] Y_CEIL_W   = 11'(Y_CEIL);
  localparam logic [3:0]  JUMP_V0_W  = 4'(JUMP_V0);
  localparam logic [3:0]  GRAVITY_4  = 4'(GRAVITY);
  localparam logic [4:0]  GRAVITY_5  = 5'(GRAVITY);
  localparam logic [3:0]  V_MAX_4    = 4'(V_MAX);
  localparam logic [4:0]  V_MAX_5    = 5'(V_MAX);

  state_t     state_reg, state_next;
  logic [9:0] mario_y_reg, mario_y_next;
  logic [3:0] vy_reg, vy_next;
  logic       airborne_reg, airborne_next;
  logic       jump_pend_reg, jump_pend_next;
  logic       btn_prev_reg;

  logic        press;
  logic [10:0] rise_diff;
  logic        rise_clamp;
  logic [9:0]  rise_y;
  logic [3:0]  rise_vy;
  logic [4:0]  fall_vy_sum;
  logic [3:0]  fall_vy;
  logic [10:0] fall_sum;
  logic        fall_land;

  assign press = btn_jump & ~btn_prev_reg;

  // Rising step: 11-bit difference so a step past the top shows up in bit 10 instead of wrapping.
  assign rise_diff  = {1'b0, mario_y_reg} - {7'd0, vy_reg};
  assign rise_clamp = rise_diff[10] || (rise_diff < Y_CEIL_W);
  assign rise_y     = rise_clamp ? Y_CEIL_Y : rise_diff[9:0];
  assign rise_vy    = (vy_reg >= GRAVITY_4) ? (vy_reg - GRAVITY_4) : 4'd0;

  // Falling step: accelerate first, then move by the new speed.
  assign fall_vy_sum = {1'b0, vy_reg} + GRAVITY_5;
  assign fall_vy     = (fall_vy_sum > V_MAX_5) ? V_MAX_4 : fall_vy_sum[3:0];
  assign fall_sum    = {1'b0, mario_y_reg} + {7'd0, fall_vy};
  assign fall_land   = (fall_sum >= Y_FLOOR_W);

  always_comb begin
    state_next     = state_reg;
    mario_y_next   = mario_y_reg;
    vy_next        = vy_reg;
    jump_pend_next = jump_pend_reg;

    if (press) begin
      jump_pend_next = 1'b1;
    end

    if (frame_tick) begin
      // Every tick drops the pending press, used or not, so presses never carry across frames.
      jump_pend_next = 1'b0;
      case (state_reg)
        ST_GROUND: begin
          if (!ground) begin
            state_next = ST_FALL;
            vy_next    = 4'd0;
          end else if (jump_pend_reg || press) begin
            state_next = ST_RISE;
            vy_next    = JUMP_V0_W;
          end
        end
        ST_RISE: begin
          if (head_hit) begin
            state_next = ST_FALL;
            vy_next    = 4'd0;
          end else begin
            mario_y_next = rise_y;
            if ((rise_vy == 4'd0) || rise_clamp) begin
              state_next = ST_FALL;
              vy_next    = 4'd0;
            end else begin
              vy_next = rise_vy;
            end
          end
        end
        ST_FALL: begin
          if (ground) begin
            state_next = ST_GROUND;
            vy_next    = 4'd0;
          end else if (fall_land) begin
            state_next   = ST_GROUND;
            vy_next      = 4'd0;
            mario_y_next = Y_FLOOR_Y;
          end else begin
            vy_next      = fall_vy;
            mario_y_next = fall_sum[9:0];
          end
        end
        default: begin
          state_next = ST_FALL;
          vy_next    = 4'd0;
        end
      endcase
    end

    airborne_next = (state_next != ST_GROUND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_GROUND;
      mario_y_reg   <= Y_INIT_W;
      vy_reg        <= 4'd0;
      airborne_reg  <= 1'b0;
      jump_pend_reg <= 1'b0;
      btn_prev_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mario_y_reg   <= mario_y_next;
      vy_reg        <= vy_next;
      airborne_reg  <= airborne_next;
      jump_pend_reg <= jump_pend_next;
      btn_prev_reg  <= btn_jump;
    end
  end

  assign mario_y  = mario_y_reg;
  assign vy       = vy_reg;
  assign state    = state_reg;
  assign airborne = airborne_reg;

endmodule

// File: tb/tb_mario_jump_ctrl.sv
// Directed bench for mario_jump_ctrl; a second instance with Y_INIT=200 covers the walk-off case.
module tb_mario_jump_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_jump = 1'b0;
  logic       ground = 1'b1;
  logic       head_hit = 1'b0;
  logic [9:0] mario_y;
  logic [3:0] vy;
  logic [1:0] state;
  logic       airborne;

  logic       btn_b = 1'b0;
  logic       ground_b = 1'b1;
  logic       head_b = 1'b0;
  logic [9:0] mario_y_b;
  logic [3:0] vy_b;
  logic [1:0] state_b;
  logic       airborne_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mario_jump_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .btn_jump(btn_jump),
    .ground(ground), .head_hit(head_hit), .mario_y(mario_y), .vy(vy),
    .state(state), .airborne(airborne)
  );

  mario_jump_ctrl #(.Y_INIT(200)) dut_b (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .btn_jump(btn_b),
    .ground(ground_b), .head_hit(head_b), .mario_y(mario_y_b), .vy(vy_b),
    .state(state_b), .airborne(airborne_b)
  );

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_btn();
    @(negedge clk);
    btn_jump = 1'b1;
    @(posedge clk);
    #1;
    btn_jump = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_vec++; if (mario_y !== 10'd407) begin n_err++; $display("FAIL reset_y: got %0d expected 407", mario_y); end
    n_vec++; if (vy !== 4'd0) begin n_err++; $display("FAIL reset_vy: got %0d expected 0", vy); end
    n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_vec++; if (airborne !== 1'b0) begin n_err++; $display("FAIL reset_airborne: got %0d expected 0", airborne); end
    n_vec++; if (mario_y_b !== 10'd200) begin n_err++; $display("FAIL reset_y_b: got %0d expected 200", mario_y_b); end
  endtask

  task automatic test_walk_off();
    ground_b = 1'b0;
    tick();
    n_vec++; if (state_b !== 2'd2 || vy_b !== 4'd0 || mario_y_b !== 10'd200)
      begin n_err++; $display("FAIL walk_off: got st=%0d vy=%0d y=%0d expected st=2 vy=0 y=200", state_b, vy_b, mario_y_b); end
    n_vec++; if (airborne_b !== 1'b1) begin n_err++; $display("FAIL walk_off_air: got %0d expected 1", airborne_b); end
    tick();
    n_vec++; if (state_b !== 2'd2 || vy_b !== 4'd1 || mario_y_b !== 10'd201)
      begin n_err++; $display("FAIL walk_off_fall: got st=%0d vy=%0d y=%0d expected st=2 vy=1 y=201", state_b, vy_b, mario_y_b); end
    ground_b = 1'b1;
    tick();
    n_vec++; if (state_b !== 2'd0 || vy_b !== 4'd0 || mario_y_b !== 10'd201 || airborne_b !== 1'b0)
      begin n_err++; $display("FAIL walk_off_land: got st=%0d vy=%0d y=%0d air=%0d expected st=0 vy=0 y=201 air=0", state_b, vy_b, mario_y_b, airborne_b); end
  endtask

  task automatic test_full_jump();
    ground = 1'b1;
    press_btn();
    n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL jump_no_tick_hold: got st=%0d expected 0", state); end
    tick();
    n_vec++; if (state !== 2'd1 || vy !== 4'd12 || mario_y !== 10'd407 || airborne !== 1'b1)
      begin n_err++; $display("FAIL jump_launch: got st=%0d vy=%0d y=%0d air=%0d expected st=1 vy=12 y=407 air=1", state, vy, mario_y, airborne); end
    ground = 1'b0;
    tick();
    n_vec++; if (mario_y !== 10'd395 || vy !== 4'd11) begin n_err++; $display("FAIL jump_rise1: got y=%0d vy=%0d expected y=395 vy=11", mario_y, vy); end
    ticks(11);
    n_vec++; if (mario_y !== 10'd329 || state !== 2'd2 || vy !== 4'd0)
      begin n_err++; $display("FAIL jump_apex: got y=%0d st=%0d vy=%0d expected y=329 st=2 vy=0", mario_y, state, vy); end
    ticks(8);
    n_vec++; if (mario_y !== 10'd365 || vy !== 4'd8) begin n_err++; $display("FAIL jump_fall8: got y=%0d vy=%0d expected y=365 vy=8", mario_y, vy); end
    ticks(5);
    n_vec++; if (mario_y !== 10'd405 || state !== 2'd2) begin n_err++; $display("FAIL jump_fall13: got y=%0d st=%0d expected y=405 st=2", mario_y, state); end
    tick();
    n_vec++; if (mario_y !== 10'd407 || state !== 2'd0 || vy !== 4'd0 || airborne !== 1'b0)
      begin n_err++; $display("FAIL jump_land: got y=%0d st=%0d vy=%0d air=%0d expected y=407 st=0 vy=0 air=0", mario_y, state, vy, airborne); end
    ground = 1'b1;
  endtask

  task automatic test_head_bump();
    press_btn();
    tick();
    ground = 1'b0;
    ticks(3);
    n_vec++; if (state !== 2'd1 || vy !== 4'd9 || mario_y !== 10'd374)
      begin n_err++; $display("FAIL bump_setup: got st=%0d vy=%0d y=%0d expected st=1 vy=9 y=374", state, vy, mario_y); end
    head_hit = 1'b1;
    tick();
    head_hit = 1'b0;
    n_vec++; if (state !== 2'd2 || vy !== 4'd0 || mario_y !== 10'd374)
      begin n_err++; $display("FAIL bump: got st=%0d vy=%0d y=%0d expected st=2 vy=0 y=374", state, vy, mario_y); end
    ground = 1'b1;
    tick();
    n_vec++; if (state !== 2'd0 || mario_y !== 10'd374) begin n_err++; $display("FAIL bump_land: got st=%0d y=%0d expected st=0 y=374", state, mario_y); end
  endtask

  task automatic test_press_airborne();
    @(negedge clk);
    btn_jump = 1'b1;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    btn_jump = 1'b0;
    n_vec++; if (state !== 2'd1 || vy !== 4'd12 || mario_y !== 10'd374)
      begin n_err++; $display("FAIL press_on_tick: got st=%0d vy=%0d y=%0d expected st=1 vy=12 y=374", state, vy, mario_y); end
    ground = 1'b0;
    tick();
    n_vec++; if (mario_y !== 10'd362 || vy !== 4'd11) begin n_err++; $display("FAIL air_rise: got y=%0d vy=%0d expected y=362 vy=11", mario_y, vy); end
    press_btn();
    tick();
    head_hit = 1'b1;
    tick();
    head_hit = 1'b0;
    ground = 1'b1;
    tick();
    n_vec++; if (state !== 2'd0 || mario_y !== 10'd351) begin n_err++; $display("FAIL air_land: got st=%0d y=%0d expected st=0 y=351", state, mario_y); end
    ticks(2);
    n_vec++; if (state !== 2'd0 || vy !== 4'd0 || airborne !== 1'b0)
      begin n_err++; $display("FAIL air_press_discard: got st=%0d vy=%0d air=%0d expected st=0 vy=0 air=0", state, vy, airborne); end
  endtask

  task automatic test_hold();
    @(negedge clk);
    btn_jump = 1'b1;
    tick();
    n_vec++; if (state !== 2'd1 || vy !== 4'd12) begin n_err++; $display("FAIL hold_first_jump: got st=%0d vy=%0d expected st=1 vy=12", state, vy); end
    head_hit = 1'b1;
    tick();
    head_hit = 1'b0;
    tick();
    ticks(3);
    n_vec++; if (state !== 2'd0 || mario_y !== 10'd351) begin n_err++; $display("FAIL hold_single_jump: got st=%0d y=%0d expected st=0 y=351", state, mario_y); end
    btn_jump = 1'b0;
  endtask

  task automatic test_reset_midair();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    press_btn();
    tick();
    ground = 1'b0;
    ticks(6);
    n_vec++; if (state !== 2'd1 || mario_y !== 10'd350 || vy !== 4'd6)
      begin n_err++; $display("FAIL midair_setup: got st=%0d y=%0d vy=%0d expected st=1 y=350 vy=6", state, mario_y, vy); end
    press_btn();
    @(negedge clk);
    rst = 1'b1;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    frame_tick = 1'b0;
    n_vec++; if (mario_y !== 10'd407 || state !== 2'd0 || vy !== 4'd0 || airborne !== 1'b0)
      begin n_err++; $display("FAIL midair_reset: got y=%0d st=%0d vy=%0d air=%0d expected y=407 st=0 vy=0 air=0", mario_y, state, vy, airborne); end
    ground = 1'b1;
    tick();
    n_vec++; if (state !== 2'd0 || mario_y !== 10'd407) begin n_err++; $display("FAIL midair_pend_cleared: got st=%0d y=%0d expected st=0 y=407", state, mario_y); end
  endtask

  initial begin
    test_reset();
    test_walk_off();
    test_full_jump();
    test_head_bump();
    test_press_airborne();
    test_hold();
    test_reset_midair();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
